// File: rtl/button_pulse_conditioner_pkg.sv
// Shared types and defaults for the button pulse conditioner.
//   btn_state_t      : per-channel debounce FSM state (2-bit encoding)
//   DEBOUNCE_DEFAULT : default number of stable cycles needed to accept a level
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/button_pulse_conditioner_if.sv
// Button/pulse bundle between the raw push buttons and the PWM duty stage.
//   increase_btn / decrease_btn             : raw asynchronous buttons, active-high
//   increase_duty_sync / decrease_duty_sync : one-cycle registered press pulses
//   btn_busy                                : either channel is not IDLE
// slave  : the conditioner side (consumes buttons, drives pulses)
// master : the driving side (drives buttons, consumes pulses)
interface button_pulse_conditioner_if;

  logic increase_btn;
  logic decrease_btn;
  logic increase_duty_sync;
  logic decrease_duty_sync;
  logic btn_busy;

  modport slave (
    input  increase_btn,
    input  decrease_btn,
    output increase_duty_sync,
    output decrease_duty_sync,
    output btn_busy
  );

  modport master (
    output increase_btn,
    output decrease_btn,
    input  increase_duty_sync,
    input  decrease_duty_sync,
    input  btn_busy
  );

endinterface

// File: rtl/button_pulse_conditioner_btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM with counter, and a
// combinational pre-pulse asserted on the edge a press is accepted.
// Optional feature macro: BTN_AUTOREPEAT_EN (repeat pulses while held).
// Ports:
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_btn_raw    : raw asynchronous button level
//   o_pulse_pre  : high in the cycle whose edge accepts a press (or repeat)
//   o_busy       : registered, high whenever the FSM is not IDLE
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 8
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int HOLD_CYCLES     = 200,
  parameter int REPEAT_CYCLES   = 50
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_raw,
  output logic o_pulse_pre,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             r_sync1;
  logic             r_sync2;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  btn_state_t       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_pulse_pre;
`ifdef BTN_AUTOREPEAT_EN
  // Set once the first (long) hold delay has elapsed; later repeats use
  // the shorter repeat interval.
  logic             r_rep;
  logic             w_next_rep;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_rep   <= 1'b0;
`endif
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      // Busy tracks the state register itself, so it updates on the same edge.
      r_busy  <= (w_next_state != IDLE);
`ifdef BTN_AUTOREPEAT_EN
      r_rep   <= w_next_rep;
`endif
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pulse_pre  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    w_next_rep   = r_rep;
`endif
    case (r_state)
      IDLE: begin
        if (r_sync2) begin
          w_next_state = PRESS_WAIT;
          w_next_cnt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_sync2) begin
          w_next_state = IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_next_state = HELD;
          w_pulse_pre  = 1'b1;
          w_next_cnt   = '0;
`ifdef BTN_AUTOREPEAT_EN
          w_next_rep   = 1'b0;
`endif
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!r_sync2) begin
          w_next_state = RELEASE_WAIT;
          w_next_cnt   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (r_cnt == (r_rep ? REP_LAST : HOLD_LAST)) begin
          w_pulse_pre = 1'b1;
          w_next_cnt  = '0;
          w_next_rep  = 1'b1;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        // A bounce back to 1 returns to HELD silently; only a fresh press pulses.
        if (r_sync2) begin
          w_next_state = HELD;
          w_next_cnt   = '0;
`ifdef BTN_AUTOREPEAT_EN
          w_next_rep   = 1'b0;
`endif
        end else if (r_cnt == DB_LAST) begin
          w_next_state = IDLE;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign o_pulse_pre = w_pulse_pre;
  assign o_busy      = r_busy;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Front end for the PWM duty controller: turns the raw "duty up" and
// "duty down" buttons into clean one-cycle pulses, one per accepted press.
// Optional feature macro: BTN_AUTOREPEAT_EN (repeat pulses while held).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : button_pulse_conditioner_if.slave
//           (increase_btn, decrease_btn in; increase_duty_sync,
//            decrease_duty_sync, btn_busy out)
module button_pulse_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 8,
  parameter int HOLD_CYCLES     = 200,
  parameter int REPEAT_CYCLES   = 50
) (
  input  logic                        clk,
  input  logic                        rst_n,
  button_pulse_conditioner_if.slave   bus
);

  localparam int MAX_CNT =
    (DEBOUNCE_CYCLES > HOLD_CYCLES)
      ? ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES)
      : ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);

  generate
    if (DEBOUNCE_CYCLES < 2 || MAX_CNT > (1 << CNT_W)) begin : g_param_err
      $error("button_pulse_conditioner: DEBOUNCE_CYCLES < 2 or CNT_W too narrow");
    end
  endgenerate

  logic w_up_pre;
  logic w_dn_pre;
  logic w_up_busy;
  logic w_dn_busy;
  logic r_inc;
  logic r_dec;

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
  ) u_up (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_btn_raw   (bus.increase_btn),
    .o_pulse_pre (w_up_pre),
    .o_busy      (w_up_busy)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
  ) u_dn (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_btn_raw   (bus.decrease_btn),
    .o_pulse_pre (w_dn_pre),
    .o_busy      (w_dn_busy)
  );

  // Simultaneous up/down requests are ambiguous, so both are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
    end else begin
      r_inc <= w_up_pre & ~w_dn_pre;
      r_dec <= w_dn_pre & ~w_up_pre;
    end
  end

  assign bus.increase_duty_sync = r_inc;
  assign bus.decrease_duty_sync = r_dec;
  assign bus.btn_busy           = w_up_busy | w_dn_busy;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
module tb_button_pulse_conditioner;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  button_pulse_conditioner_if bus();

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (8),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] up;
    logic [63:0] dn;
    logic [63:0] e_up;
    logic [63:0] e_dn;
    logic [63:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  // Bit k of a stimulus mask is the raw level sampled at edge k; bit k of an
  // expected mask is the output value just after edge k.
  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_vec(input logic [63:0] up, input logic [63:0] dn,
                         output logic [63:0] gu, output logic [63:0] gd,
                         output logic [63:0] gb);
    gu = '0; gd = '0; gb = '0;
    for (int k = 0; k < 64; k++) begin
      bus.increase_btn = up[k];
      bus.decrease_btn = dn[k];
      @(posedge clk);
      @(negedge clk);
      gu[k] = bus.increase_duty_sync;
      gd[k] = bus.decrease_duty_sync;
      gb[k] = bus.btn_busy;
    end
    bus.increase_btn = 1'b0;
    bus.decrease_btn = 1'b0;
  endtask

  task automatic add(input string n, input logic [63:0] up, input logic [63:0] dn,
                     input logic [63:0] eu, input logic [63:0] ed, input logic [63:0] eb);
    vec_t v;
    v.name = n; v.up = up; v.dn = dn; v.e_up = eu; v.e_dn = ed; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  initial begin
    logic [63:0] gu, gd, gb;
    logic [63:0] cap;
    n_tests = 0;
    n_fail  = 0;

    // Stimulus table
`ifdef BTN_AUTOREPEAT_EN
    add("clean_press",   rng(0, 19), '0, rng(6, 6) | rng(16, 16) | rng(21, 21), '0, rng(2, 25));
`else
    add("clean_press",   rng(0, 19), '0, rng(6, 6), '0, rng(2, 25));
`endif
    add("bounce",        rng(0, 0) | rng(2, 2) | rng(4, 4), '0, '0, '0,
                         rng(2, 2) | rng(4, 4) | rng(6, 6));
    add("release_bounce", rng(0, 9) | rng(11, 11) | rng(13, 19), '0, rng(6, 6), '0, rng(2, 25));
    add("simultaneous",  rng(0, 19), rng(0, 19), '0, '0, rng(2, 25));
    add("single_down",   '0, rng(0, 9), '0, rng(6, 6), rng(2, 15));
    add("staggered",     rng(0, 9), rng(1, 10), rng(6, 6), rng(7, 7), rng(2, 16));
    add("short_press_4", rng(0, 3), '0, '0, '0, rng(2, 5));
    add("min_press_5",   rng(0, 4), '0, rng(6, 6), '0, rng(2, 10));
    add("up_after_conflict", rng(0, 9), '0, rng(6, 6), '0, rng(2, 15));
`ifdef BTN_AUTOREPEAT_EN
    add("autorepeat_40", rng(0, 39), '0,
        rng(6, 6) | rng(16, 16) | rng(21, 21) | rng(26, 26) | rng(31, 31) | rng(36, 36) | rng(41, 41),
        '0, rng(2, 45));
`endif

    // Reset state
    rst_n = 1'b0;
    bus.increase_btn = 1'b0;
    bus.decrease_btn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_inc",  {63'd0, bus.increase_duty_sync}, '0);
    chk("reset_dec",  {63'd0, bus.decrease_duty_sync}, '0);
    chk("reset_busy", {63'd0, bus.btn_busy}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_vec(vecs[i].up, vecs[i].dn, gu, gd, gb);
      chk({vecs[i].name, "_inc"},  gu, vecs[i].e_up);
      chk({vecs[i].name, "_dec"},  gd, vecs[i].e_dn);
      chk({vecs[i].name, "_busy"}, gb, vecs[i].e_busy);
      chk({vecs[i].name, "_both_high"}, gu & gd, '0);
    end

    // Reset mid-press: asserted between edge 4 and edge 5, button kept high
    bus.increase_btn = 1'b1;
    repeat (4) @(negedge clk);       // edges 0..3 done
    @(posedge clk);                  // edge 4
    #2;
    chk("midpress_busy_before", {63'd0, bus.btn_busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midpress_busy_in_reset", {63'd0, bus.btn_busy}, '0);
    chk("midpress_inc_in_reset",  {63'd0, bus.increase_duty_sync}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cap = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      cap[k] = bus.increase_duty_sync;
    end
    chk("midpress_after_release", cap, rng(6, 6));
    bus.increase_btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("midpress_idle_busy", {63'd0, bus.btn_busy}, '0);

    // Reset while the output pulse is high clears it at once
    bus.decrease_btn = 1'b1;
    repeat (6) @(negedge clk);       // edges 0..5 done
    @(posedge clk);                  // edge 6
    @(negedge clk);
    chk("pulse_high_before_reset", {63'd0, bus.decrease_duty_sync}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("pulse_cleared_by_reset", {63'd0, bus.decrease_duty_sync}, '0);
    bus.decrease_btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cap = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      cap[k] = bus.decrease_duty_sync | bus.increase_duty_sync;
    end
    chk("no_pulse_after_reset_release", cap, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
